// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam logic [15:0] DIV_MIN = 16'd2;

  function automatic logic [15:0] eff_divisor(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous write FIFO; writes while full are dropped, fullness judged before any pop.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed serial transmitter: write FIFO feeding a start/data/parity/stop FSM, txd from a flop.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_t     PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   divisor,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx_start,
  output logic                          txd,
  output logic                          tbr
);

  tx_state_t            state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          div_q, div_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [3:0]           idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 start_q, start_d;
  logic                 overflow_q;

  logic                 fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 bit_end, start_frame, par_bit;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_data),
    .full_o    (full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  assign bit_end  = (cnt_q == 16'd1);
  assign par_bit  = (PARITY == PARITY_ODD) ? ~par_q : par_q;
  assign txd      = txd_q;
  assign tx_start = start_q;
  assign overflow = overflow_q;
  assign tbr      = (state_q == IDLE) && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_MIN;
      sh_q       <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      start_q    <= start_d;
      overflow_q <= wr_en && full;
    end
  end

  // Each branch sets the txd value for the bit that begins at the next edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - 16'd1;
    div_d       = div_q;
    sh_d        = sh_q;
    idx_d       = idx_q;
    par_d       = par_q;
    txd_d       = txd_q;
    start_d     = 1'b0;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        txd_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = div_q;
          txd_d   = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = PAR;
              txd_d   = par_bit;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            txd_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = div_q;
          idx_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame start is shared by IDLE and the back-to-back path out of STOP.
    if (start_frame) begin
      fifo_pop = 1'b1;
      state_d  = START;
      sh_d     = fifo_data;
      par_d    = ^fifo_data;
      cnt_d    = eff_divisor(divisor);
      div_d    = eff_divisor(divisor);
      idx_d    = '0;
      txd_d    = 1'b0;
      start_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench: writes push expected frames, per-DUT monitors check every bit cycle.
module tb_uart_tx_framed;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] div_a, div_b;
  logic        wr_en_a, wr_en_b;
  logic [7:0]  wr_data_a;
  logic [6:0]  wr_data_b;
  logic        full_a, ovf_a, txs_a, txd_a, tbr_a;
  logic        full_b, ovf_b, txs_b, txd_b, tbr_b;
  logic [2:0]  count_a, count_b;

  uart_tx_framed dut_a (
    .clk(clk), .rst_n(rst_n), .divisor(div_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .count(count_a), .overflow(ovf_a), .tx_start(txs_a), .txd(txd_a), .tbr(tbr_a)
  );

  uart_tx_framed #(
    .DATA_BITS(7), .PARITY(PARITY_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .divisor(div_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .count(count_b), .overflow(ovf_b), .tx_start(txs_b), .txd(txd_b), .tbr(tbr_b)
  );

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          div;
  } frame_t;

  frame_t q_a[$], q_b[$];
  int     stamps[$];
  int     n_checks = 0, n_fail = 0;
  int     cyc = 0, frames_a = 0, frames_b = 0, ovf_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ovf_a) ovf_pulses <= ovf_pulses + 1;

  function automatic logic txs(input int s);  return (s == 0) ? txs_a : txs_b; endfunction
  function automatic logic txdv(input int s); return (s == 0) ? txd_a : txd_b; endfunction
  function automatic logic tbrv(input int s); return (s == 0) ? tbr_a : tbr_b; endfunction
  function automatic int   qsize(input int s); return (s == 0) ? q_a.size() : q_b.size(); endfunction

  function automatic frame_t f8(input logic [7:0] d, input int div);
    frame_t f;
    f.bits = {6'b0, 1'b1, d, 1'b0};
    f.n    = 10;
    f.div  = div;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor(input int s);
    frame_t f;
    bit     abort, ok;
    forever begin
      @(negedge clk);
      if (rst_n && txs(s)) begin
        if (s == 0) begin frames_a++; stamps.push_back(cyc); end
        else frames_b++;
        n_checks++;
        if (qsize(s) == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame[%0d]: got a tx_start, expected no frame", s);
        end else begin
          f = (s == 0) ? q_a.pop_front() : q_b.pop_front();
          abort = 1'b0;
          for (int i = 0; i < f.n && !abort; i++) begin
            ok = 1'b1;
            for (int c = 0; c < f.div; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (!rst_n) begin abort = 1'b1; break; end
              if (txdv(s) !== f.bits[i]) ok = 1'b0;
              if ((i != 0 || c != 0) && txs(s) !== 1'b0) ok = 1'b0;
            end
            if (!abort) begin
              n_checks++;
              if (!ok) begin
                n_fail++;
                $display("FAIL frame_bit[%0d] bit %0d: txd/tx_start not held, expected txd=%0b for %0d clocks",
                         s, i, f.bits[i], f.div);
              end
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_idle(input int s, input int limit);
    int k = 0;
    while (!(tbrv(s) && qsize(s) == 0) && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_reached", 32'(k < limit), 32'd1);
  endtask

  task automatic frame_len(input int s, input int len);
    int k = 0;
    while (!txs(s) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("frame_start_seen", 32'(txs(s)), 32'd1);
    repeat (len - 1) @(posedge clk);
    #1 chk("tbr_low_last_stop", 32'(tbrv(s)), 32'd0);
    @(posedge clk);
    #1 chk("tbr_high_after_frame", 32'(tbrv(s)), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst_n = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
    wr_data_a = '0; wr_data_b = '0; div_a = 16'd4; div_b = 16'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd_a), 32'd1);
    chk("rst_tbr", 32'(tbr_a), 32'd1);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_overflow", 32'(ovf_a), 32'd0);
    chk("rst_tx_start", 32'(txs_a), 32'd0);
    chk("rst_txd_b", 32'(txd_b), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8N1, divisor 4, 0xA5 with write-to-start latency
    wr_en_a = 1'b1; wr_data_a = 8'hA5;
    q_a.push_back('{bits: 16'({1'b1, 8'hA5, 1'b0}), n: 10, div: 4});
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    chk("count_after_write", 32'(count_a), 32'd1);
    chk("tbr_falls_with_count", 32'(tbr_a), 32'd0);
    @(posedge clk); #1;
    chk("tx_start_latency", 32'(txs_a), 32'd1);
    chk("txd_start_bit", 32'(txd_a), 32'd0);
    chk("count_after_pop", 32'(count_a), 32'd0);
    frame_len(0, 40);
    chk("one_tx_start", 32'(frames_a), 32'd1);

    // 7O2, divisor 3, 0x55
    wr_en_b = 1'b1; wr_data_b = 7'h55;
    q_b.push_back('{bits: 16'({2'b11, 1'b1, 7'h55, 1'b0}), n: 11, div: 3});
    @(posedge clk); #1;
    wr_en_b = 1'b0;
    frame_len(1, 33);
    chk("b_frames", 32'(frames_b), 32'd1);

    // back-to-back frames, divisor 2
    div_a = 16'd2;
    stamps.delete();
    for (int i = 1; i <= 3; i++) begin
      wr_en_a = 1'b1; wr_data_a = 8'(i);
      q_a.push_back(f8(8'(i), 2));
      @(posedge clk); #1;
    end
    wr_en_a = 1'b0;
    wait_idle(0, 200);
    chk("b2b_frames", 32'(stamps.size()), 32'd3);
    if (stamps.size() == 3) begin
      chk("b2b_gap_1", 32'(stamps[1] - stamps[0]), 32'd20);
      chk("b2b_gap_2", 32'(stamps[2] - stamps[1]), 32'd20);
    end

    // six writes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        chk("full_on_fifth", 32'(full_a), 32'd1);
        chk("count_on_fifth", 32'(count_a), 32'd4);
      end
      wr_en_a = 1'b1; wr_data_a = 8'(8'h10 + i);
      if (i < 5) q_a.push_back(f8(8'(8'h10 + i), 2));
      @(posedge clk); #1;
    end
    wr_en_a = 1'b0;
    chk("overflow_pulse", 32'(ovf_a), 32'd1);
    chk("count_after_drop", 32'(count_a), 32'd4);
    @(posedge clk); #1;
    chk("overflow_one_cycle", 32'(ovf_a), 32'd0);
    wait_idle(0, 400);
    chk("overflow_count", 32'(ovf_pulses), 32'd1);
    chk("frames_after_overflow", 32'(frames_a), 32'd9);

    // divisor change during bit 3
    div_a = 16'd4;
    wr_en_a = 1'b1; wr_data_a = 8'h3C; q_a.push_back(f8(8'h3C, 4));
    @(posedge clk); #1;
    wr_data_a = 8'hC3; q_a.push_back(f8(8'hC3, 8));
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    chk("div_frame_started", 32'(txs_a), 32'd1);
    repeat (13) @(posedge clk);
    #1 div_a = 16'd8;
    wait_idle(0, 600);

    // reset mid-frame with two entries queued
    div_a = 16'd4;
    for (int i = 0; i < 3; i++) begin
      wr_en_a = 1'b1; wr_data_a = 8'(8'h11 * (i + 1));
      q_a.push_back(f8(8'(8'h11 * (i + 1)), 4));
      @(posedge clk); #1;
    end
    wr_en_a = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("queued_before_reset", 32'(count_a), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_txd", 32'(txd_a), 32'd1);
    chk("async_rst_count", 32'(count_a), 32'd0);
    chk("async_rst_tbr", 32'(tbr_a), 32'd1);
    q_a.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    saved = frames_a;
    repeat (60) @(posedge clk);
    #1;
    chk("no_frame_after_reset", 32'(frames_a), 32'(saved));
    chk("idle_txd_after_reset", 32'(txd_a), 32'd1);
    wr_en_a = 1'b1; wr_data_a = 8'h5A; q_a.push_back(f8(8'h5A, 4));
    @(posedge clk); #1;
    wr_en_a = 1'b0;
    wait_idle(0, 200);
    chk("frame_after_reset", 32'(frames_a), 32'(saved + 1));
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
